dec_scan_ctrl: RTL and testbench
================================

Name: dec_scan_ctrl

Overview:
Upstream sequencer for the 3-to-8 enable decoder. It drives the decoder's `en` and `sel` inputs. On a start request it walks the enabled output lines in ascending line order and activates each line for a programmable dwell time. It guarantees `sel` never changes while `en` is high, so the gate-level decoder cannot produce glitch pulses on `d`. Mapping is fixed: decoder output line d[i] is selected by sel = 7 - i (bitwise NOT of i).

Parameters:
DWELL, 4, cycles `en` is held high per line; legal range 1..255
CW, 8, width of the internal dwell counter; must satisfy 2**CW > DWELL

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle scan request; sampled only in IDLE
abort  input  1  synchronous cancel; honoured in any non-IDLE state
hold  input  1  freezes the dwell counter while high; `en` and `sel` unchanged
cont  input  1  sampled with `start`; 1 = wrap to the lowest enabled line forever; 0 = single pass
mask  input  8  enabled lines, bit i = d[i]; sampled with `start`
en  output  1  decoder enable, registered
sel  output  3  decoder select, registered
cur_line  output  3  line index currently addressed (= ~sel)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a single pass completes

Behaviour:
- Reset (async, any state): state=IDLE, en=0, sel=3'b000, cur_line=3'd7, busy=0, done=0, counter=0, latched mask=0, latched cont=0. `en` falls immediately on rst assertion, independent of clk.
- States:
  - IDLE: waits for `start`.
    - On `start`, latch `mask` and `cont`.
    - If the latched mask is nonzero, go to SETUP with the lowest set index i.
    - If the latched mask is 0, go to DONE.
  - SETUP (1 cycle): sel=~i, cur_line=i, en=0. Next state is DWELL; load counter=DWELL-1.
  - DWELL: en=1.
    - Counter decrements each cycle that hold=0 and holds its value while hold=1.
    - When counter==0 and hold=0, search for the next set bit above i.
    - If found, go to SETUP with that index.
    - Else if cont=1, go to SETUP with the lowest set bit.
    - Else go to DONE.
  - DONE (1 cycle): done=1, en=0. Next state is IDLE.
- Timing: a start sampled at edge k gives SETUP in cycle k+1 and en=1 in cycles k+2 .. k+1+DWELL. Each further line costs DWELL+1 cycles.
- `sel` changes only on entry to SETUP, and `en` is 0 throughout SETUP (break-before-make).
- A single-bit mask with cont=1 still re-enters SETUP between dwells, giving one cycle with en low.
- abort: takes priority over hold and dwell expiry. The next state is IDLE with en=0, and no done pulse is generated. `sel` keeps its last value.
- `start` is ignored while busy=1.
- In IDLE, `start` and `abort` asserted in the same cycle: start wins, because abort is ignored in IDLE.
- `mask` and `cont` changes after start have no effect until the next start.
- In DONE, `en` is 0 and `sel` keeps its last value.

Decomposition:
- Package dec_scan_pkg holds:
  - state enum: IDLE, SETUP, DWELL, DONE
  - LINES=8
  - function line_to_sel(i) = ~i
- One combinational sub-module, dec_next_line.
  - Inputs: mask[7:0], cur[2:0], wrap.
  - Outputs: nxt[2:0], found.
  - Function: returns the lowest set bit strictly above cur; if wrap=1 it falls back to the lowest set bit overall.
  - Also used with a first-search flag to find the lowest set bit on start.

Test Plan:
1. Reset and basic pass. DWELL=4, mask=8'b0010_0101, cont=0, start pulsed at edge k. Expected response:
   - SETUP sel=7 at k+1, en=1 at k+2..k+5.
   - SETUP sel=5 at k+6, en=1 at k+7..k+10.
   - SETUP sel=2 at k+11, en=1 at k+12..k+15.
   - done=1 at k+16, busy=0 at k+17.
   - Every cycle where sel changes has en=0.
2. Empty mask. mask=0, start -> done=1 exactly one cycle after start; en never rises.
3. Hold. mask=8'h01, hold high for 3 cycles mid-dwell -> en high for 7 cycles total, sel=7 throughout, done one cycle after en falls.
4. Abort. mask=8'hFF, abort during the 2nd line's dwell -> en=0 the next cycle, busy=0, no done pulse. A subsequent start restarts from sel=7.
5. Continuous wrap. mask=8'b1000_0001, cont=1 -> sel sequence 7,0,7,0,... with one en-low cycle between each; done never asserts.
6. Async reset mid-dwell. rst asserted between clock edges -> en=0 without waiting for clk. After release, start is accepted normally.

Source files
------------

// File: rtl/dec_scan_pkg.sv
// dec_scan_pkg: shared types and helpers for the 3-to-8 decoder scan sequencer.
//   state_t      - sequencer FSM states
//   LINES        - number of decoder output lines
//   line_to_sel  - maps a decoder output line index to its select code
package dec_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DWELL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int LINES = 8;

    // Decoder output d[i] is selected by sel = ~i.
    function automatic logic [2:0] line_to_sel(input logic [2:0] i);
        return ~i;
    endfunction

endpackage

// File: rtl/dec_scan_ctrl_next_line.sv
// dec_next_line: combinational search for the next enabled decoder line.
//   mask  [7:0] in  - enabled lines, bit i = line i
//   cur   [2:0] in  - current line; search starts strictly above it
//   wrap        in  - when nothing is above cur, fall back to the lowest set bit
//   nxt   [2:0] out - line found (0 when found=0)
//   found       out - a line was found
// Searching with cur=7 and wrap=1 yields the lowest set bit overall, which is
// how the first line of a scan is located.
module dec_next_line
    import dec_scan_pkg::*;
(
    input  logic [7:0] mask,
    input  logic [2:0] cur,
    input  logic       wrap,
    output logic [2:0] nxt,
    output logic       found
);

    always_comb begin
        nxt   = 3'd0;
        found = 1'b0;
        // Descending scan so the lowest qualifying index is the last one kept.
        for (int i = LINES - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) > cur)) begin
                nxt   = 3'(i);
                found = 1'b1;
            end
        end
        if (!found && wrap) begin
            for (int i = LINES - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    nxt   = 3'(i);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dec_scan_ctrl.sv
// dec_scan_ctrl: scan sequencer driving the en/sel inputs of a 3-to-8 enable
// decoder. On start it walks the enabled lines in ascending order, holding en
// high for DWELL cycles per line, with a one-cycle en-low SETUP slot whenever
// sel changes so the decoder never sees sel move while enabled.
//   clk, rst      - clock, asynchronous active-high reset
//   start         - scan request, sampled in IDLE only
//   abort         - cancel, honoured in any non-IDLE state
//   hold          - freezes the dwell counter
//   cont          - 1 = scan forever, 0 = single pass (sampled with start)
//   mask [7:0]    - enabled lines (sampled with start)
//   en, sel [2:0] - decoder enable/select (registered)
//   cur_line[2:0] - line currently addressed (~sel)
//   busy          - not IDLE
//   done          - one-cycle pulse at the end of a single pass
module dec_scan_ctrl
    import dec_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       hold,
    input  logic       cont,
    input  logic [7:0] mask,
    output logic       en,
    output logic [2:0] sel,
    output logic [2:0] cur_line,
    output logic       busy,
    output logic       done
);

    localparam logic [CW-1:0] LOAD = CW'(DWELL - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    sel_n;
    logic [7:0]    mask_q, mask_n;
    logic          cont_q, cont_n;

    logic [2:0]    first_line, step_line;
    logic          first_found, step_found;

    // Lowest enabled line of the incoming mask, used on start.
    dec_next_line u_first (
        .mask  (mask),
        .cur   (3'd7),
        .wrap  (1'b1),
        .nxt   (first_line),
        .found (first_found)
    );

    // Next line after the current one within the latched scan.
    dec_next_line u_step (
        .mask  (mask_q),
        .cur   (cur_line),
        .wrap  (cont_q),
        .nxt   (step_line),
        .found (step_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            sel    <= 3'b000;
            en     <= 1'b0;
            mask_q <= 8'h00;
            cont_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sel    <= sel_n;
            en     <= (state_n == S_DWELL);
            mask_q <= mask_n;
            cont_q <= cont_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        mask_n  = mask_q;
        cont_n  = cont_q;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    mask_n = mask;
                    cont_n = cont;
                    if (first_found) begin
                        state_n = S_SETUP;
                        sel_n   = line_to_sel(first_line);
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_DWELL;
                    cnt_n   = LOAD;
                end
            end
            S_DWELL: begin
                // abort outranks both hold and dwell expiry.
                if (abort) begin
                    state_n = S_IDLE;
                end else if (!hold) begin
                    if (cnt == '0) begin
                        if (step_found) begin
                            state_n = S_SETUP;
                            sel_n   = line_to_sel(step_line);
                        end else begin
                            state_n = S_DONE;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign cur_line = ~sel;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Self-checking bench for dec_scan_ctrl.
module tb_dec_scan_ctrl;

    localparam int DW = 4;
    localparam int W  = 9;   // {done, busy, en, sel, cur_line}

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, hold, cont;
    logic [7:0] mask;
    logic       en, busy, done;
    logic [2:0] sel, cur_line;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [2:0]   last_sel;
    logic [2:0]   prev_sel = 3'b000;

    dec_scan_ctrl #(.DWELL(DW), .CW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .hold     (hold),
        .cont     (cont),
        .mask     (mask),
        .en       (en),
        .sel      (sel),
        .cur_line (cur_line),
        .busy     (busy),
        .done     (done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Break-before-make: any sel change must be seen with en low.
    always @(negedge clk) begin
        if (!rst && (sel !== prev_sel))
            check("bbm_en_low_on_sel_change", {31'd0, en}, 32'd0);
        prev_sel = sel;
    end

    // ---------------- expected-trace builders ----------------
    task automatic push_line(input logic [2:0] i, input int dw);
        logic [2:0] s;
        s = ~i;
        exp_q.push_back({1'b0, 1'b1, 1'b0, s, i});
        for (int c = 0; c < dw; c++)
            exp_q.push_back({1'b0, 1'b1, 1'b1, s, i});
        last_sel = s;
    endtask

    task automatic push_pass(input logic [7:0] m, input int extra);
        for (int i = 0; i < 8; i++)
            if (m[i]) push_line(3'(i), DW + extra);
    endtask

    task automatic push_done();
        exp_q.push_back({1'b1, 1'b1, 1'b0, last_sel, ~last_sel});
        exp_q.push_back({1'b0, 1'b0, 1'b0, last_sel, ~last_sel});
    endtask

    // ---------------- drivers ----------------
    // Called at posedge+1; returns at posedge+1 of the first cycle after the
    // sampling edge. mask/cont are scrambled afterwards to show they are latched.
    task automatic do_start(input logic [7:0] m, input logic c, input logic ab);
        start = 1'b1;
        mask  = m;
        cont  = c;
        abort = ab;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        mask  = 8'($urandom_range(0, 255));
        cont  = 1'($urandom_range(0, 1));
    endtask

    // Pops one expected vector per cycle. hold is driven high for the trace
    // cycles hold_at .. hold_at+hold_len-1.
    task automatic run_trace(input string tag, input int hold_at, input int hold_len);
        int j;
        logic [W-1:0] e;
        j = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, j), {23'd0, done, busy, en, sel, cur_line}, {23'd0, e});
            hold = (j >= hold_at) && (j < hold_at + hold_len);
            j++;
            if (exp_q.size() > 0) begin
                @(posedge clk);
                #1;
            end
        end
        hold = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; cont = 1'b0; mask = 8'h00;
        last_sel = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_en", {31'd0, en}, 32'd0);
        check("reset_sel", {29'd0, sel}, 32'd0);
        check("reset_cur_line", {29'd0, cur_line}, 32'd7);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic single pass over lines 0, 2, 5.
        push_pass(8'b0010_0101, 0);
        push_done();
        do_start(8'b0010_0101, 1'b0, 1'b0);
        run_trace("basic", -1, 0);

        // Empty mask: straight to DONE, sel keeps its last value.
        push_done();
        do_start(8'h00, 1'b0, 1'b0);
        run_trace("empty", -1, 0);

        // Hold for 3 cycles mid-dwell stretches en to 7 cycles.
        push_pass(8'h01, 3);
        push_done();
        do_start(8'h01, 1'b0, 1'b0);
        run_trace("hold", 2, 3);

        // Abort during the second line's dwell.
        do_start(8'hFF, 1'b0, 1'b0);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("abort_pre_en", {31'd0, en}, 32'd1);
        check("abort_pre_sel", {29'd0, sel}, 32'd6);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_en", {31'd0, en}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sel_kept", {29'd0, sel}, 32'd6);
        for (int c = 0; c < 3; c++) begin
            check("abort_no_done", {31'd0, done}, 32'd0);
            @(posedge clk);
            #1;
        end
        last_sel = 3'd6;

        // Restart after abort begins again at line 0 (sel=7).
        push_pass(8'h03, 0);
        push_done();
        do_start(8'h03, 1'b0, 1'b0);
        run_trace("restart", -1, 0);

        // start and abort together in IDLE: start wins.
        push_pass(8'h40, 0);
        push_done();
        do_start(8'h40, 1'b0, 1'b1);
        run_trace("start_abort", -1, 0);

        // Continuous wrap 7,0,7,0 with no done, then abort.
        for (int p = 0; p < 2; p++) begin
            push_line(3'd0, DW);
            push_line(3'd7, DW);
        end
        do_start(8'b1000_0001, 1'b1, 1'b0);
        run_trace("wrap", -1, 0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("wrap_abort_busy", {31'd0, busy}, 32'd0);
        check("wrap_abort_done", {31'd0, done}, 32'd0);
        check("wrap_abort_en", {31'd0, en}, 32'd0);

        // Asynchronous reset between clock edges mid-dwell.
        do_start(8'h01, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("async_pre_en", {31'd0, en}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_en", {31'd0, en}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_sel", {29'd0, sel}, 32'd0);
        check("async_cur_line", {29'd0, cur_line}, 32'd7);
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_sel = 3'b000;
        @(posedge clk);
        #1;
        push_pass(8'h10, 0);
        push_done();
        do_start(8'h10, 1'b0, 1'b0);
        run_trace("post_reset", -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
